// File: rtl/stream_fifo_pkg.sv
// Shared definitions for stream_fifo: address-width derivation, flag reset values
// and parameter legality helpers used at elaboration.
package stream_fifo_pkg;

  localparam logic AF_RST = 1'b0;
  localparam logic AE_RST = 1'b1;

  function automatic int addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 32'sd2) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int af, input int ae);
    return (data_w >= 32'sd1) && is_pow2(depth) &&
           (af >= 32'sd1) && (af <= depth) &&
           (ae >= 32'sd0) && (ae <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module stream_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count and almost flags.
// Optional peak-occupancy tracker enabled by defining STREAM_FIFO_PEAK_EN.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W   = addr_w(DEPTH),
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef STREAM_FIFO_PEAK_EN
  input  logic              peak_clr,
  output logic [CNT_W-1:0]  peak_count,
`endif
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty
);

  if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("stream_fifo: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH");
  end

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              empty_s, full_s, push_s, pop_s;
  logic [DATA_W-1:0] rdata_s;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign s_ready = ~full_s;
  assign m_valid = ~empty_s;
  assign push_s  = s_valid & ~full_s;
  assign pop_s   = m_ready & ~empty_s;
  assign m_data  = empty_s ? {DATA_W{1'b0}} : rdata_s;

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_s & ~flush),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (s_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata_s)
  );

  // Next-state pointers, count and flags; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = ZERO;
      rd_ptr_d = ZERO;
      count_d  = ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
    af_d = (count_d >= AF_T);
    ae_d = (count_d <= AE_T);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      count_q  <= ZERO;
      af_q     <= AF_RST;
      ae_q     <= AE_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

`ifdef STREAM_FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  // Peak tracks the upcoming count; a clear reloads it from that count rather than zero
  always_comb begin
    if (peak_clr) begin
      peak_d = count_d;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= ZERO;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_count = peak_q;
`else
  // No peak tracking in this build.
`endif

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshake on both sides.
- Generalised buffering stage for streaming datapaths: configurable width and depth, occupancy count, programmable almost-full/almost-empty flags, synchronous flush.
- First-word-fall-through read: the head word is presented on m_data whenever m_valid=1.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  producer has a word.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DATA_W  write data.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer takes the head word.
- m_data  out  DATA_W  head word.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH (ADDR_W = log2(DEPTH)).
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.

Behaviour:
- Reset (rst_n=0, asynchronous): write/read pointers=0, count=0, s_ready=1, m_valid=0, m_data=0, almost_full=0, almost_empty=1. Storage array is not reset.
- Pointers:
  - ADDR_W+1 bits; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Push and pop:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
  - s_ready = !full; m_valid = !empty. Both are combinational from registered state only, with no input-to-output paths.
- Latency: a word pushed at edge N is visible on m_valid/m_data after edge N (1-cycle latency) when the FIFO was empty.
- m_data: the storage word at the read pointer when m_valid=1; forced to 0 when empty.
- count updates:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged. Data is written at the write pointer and the head advances, including at count=1.
- Boundaries:
  - Full: s_ready=0, so no write occurs; the input is held by the producer.
  - Empty: m_valid=0, so m_ready is ignored.
  - Full with pop: s_ready is still 0 that cycle (no bypass); s_ready rises next cycle.
  - Empty with push: m_valid rises next cycle (no combinational bypass).
- Flush:
  - At the clock edge, pointers and count go to 0; m_valid=0 and s_ready=1 the next cycle.
  - Flush has priority over push and pop in the same cycle; the word offered that cycle is discarded.
- Flags: registered versions of the threshold compares, evaluated on the next-state count, so they are coincident with count.
- Reset asserted mid-operation: all state immediately returns to the reset values; contents are lost.

Optional Feature:
- Macro: STREAM_FIFO_PEAK_EN.
- With the macro defined, the block adds:
  - Input peak_clr (1).
  - Output peak_count (ADDR_W+1), which records the maximum count reached since reset or since the last peak_clr.
  - peak_count updates each cycle to max(peak_count, next count).
  - peak_clr at an edge loads next count, not 0.
  - Reset value of peak_count is 0.
  - flush does not clear peak_count.
- Without the macro: neither port nor its logic exists.

Decomposition:
- Shared package:
  - Helper function clog2-based ADDR_W derivation.
  - Constants for flag reset values.
  - Parameter legality checks (DEPTH power of two, thresholds in range) as elaboration-time assertions.
- Natural sub-module: stream_fifo_mem, a DEPTH x DATA_W register array with one write port and an asynchronous read port. Control, pointers, flags and the optional peak logic stay in stream_fifo.

Test Plan:
- Reset and idle (DATA_W=8, DEPTH=16) -> after rst_n release: s_ready=1, m_valid=0, count=0, almost_empty=1, almost_full=0, m_data=0.
- Fill with m_ready=0:
  - Push 0x00..0x0F.
  - almost_full rises when count=14; s_ready=0 at count=16.
  - A 17th offered word (0xAA) is not written.
  - Drain returns 0x00..0x0F in order.
- Simultaneous push/pop at count=1 and at count=16, sustained 20 cycles with s_valid=m_ready=1 from empty:
  - count stays at 1 after the first word; throughput is 1 word/cycle.
  - Data matches the input sequence.
- Flush at count=5 with s_valid=1, s_data=0x55 in the same cycle -> next cycle count=0, m_valid=0; 0x55 is never output.
- Reset mid-stream at count=7 with rst_n pulsed low between edges -> outputs return to reset values immediately, without waiting for a clock edge.
- STREAM_FIFO_PEAK_EN defined:
  - Push 9, pop 4 -> peak_count=9.
  - peak_clr -> peak_count=5.
  - Push 2 -> peak_count=7.
  - flush -> peak_count stays 7.
